// File: rtl/param_updown_counter.sv
// Parametrised modulo up/down counter with load, enable, terminal count and wrap pulse.
// Define COUNTER_SATURATE_EN to make the count stop at its bounds instead of wrapping.
module param_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS = 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Next-state: load beats enable, enable beats hold.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = ({1'b0, din} >= MOD_EXT) ? MAX_Q : din;
    end else if (en) begin
      if (up) begin
        if (q == MAX_Q) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt = MAX_Q;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt = '0;
`else
          q_nxt    = MAX_Q;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Terminal count follows the current direction with no register delay.
  always_comb begin
    tc = (up && (q == MAX_Q)) || (!up && (q == '0));
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (WIDTH=2 full range and WIDTH=4 MODULUS=10).
module tb_param_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [1:0] q2;
  logic       tc2;
  logic       wrap2;
  logic [3:0] q10;
  logic       tc10;
  logic       wrap10;

  int n_checks;
  int n_fail;

  param_updown_counter #(.WIDTH(2)) u_w2 (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din[1:0]),
    .q    (q2),
    .tc   (tc2),
    .wrap (wrap2)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q10),
    .tc   (tc10),
    .wrap (wrap10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; din = '0;
    #12;
    n_checks++;
    if (q2 !== 2'd0) begin n_fail++; $display("FAIL reset_q2 got %0d exp 0", q2); end
    n_checks++;
    if (wrap2 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap2 got %b exp 0", wrap2); end
    n_checks++;
    if (tc2 !== 1'b1) begin n_fail++; $display("FAIL reset_tc2_down got %b exp 1", tc2); end
    n_checks++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL reset_q10 got %0d exp 0", q10); end
    up = 1'b1;
    #1;
    n_checks++;
    if (tc10 !== 1'b0) begin n_fail++; $display("FAIL reset_tc10_up got %b exp 0", tc10); end
    up = 1'b0;
  endtask

  task automatic test_down_w2();
    int exp_q [5];
    exp_q = '{3, 2, 1, 0, 3};
    @(negedge clk);
    reset = 1'b1; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (q2 !== 2'(exp_q[i])) begin n_fail++; $display("FAIL down_w2_q[%0d] got %0d exp %0d", i, q2, exp_q[i]); end
      n_checks++;
      if (wrap2 !== (exp_q[i] == 3)) begin n_fail++; $display("FAIL down_w2_wrap[%0d] got %b exp %b", i, wrap2, exp_q[i] == 3); end
      n_checks++;
      if (tc2 !== (exp_q[i] == 0)) begin n_fail++; $display("FAIL down_w2_tc[%0d] got %b exp %b", i, tc2, exp_q[i] == 0); end
    end
    en = 1'b0;
  endtask

  task automatic test_up_mod10();
    int exp_q [12];
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset = 1'b0;
    #2;
    reset = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (q10 !== 4'(exp_q[i])) begin n_fail++; $display("FAIL up_m10_q[%0d] got %0d exp %0d", i, q10, exp_q[i]); end
      n_checks++;
      if (wrap10 !== (i == 9)) begin n_fail++; $display("FAIL up_m10_wrap[%0d] got %b exp %b", i, wrap10, i == 9); end
      n_checks++;
      if (tc10 !== (exp_q[i] == 9)) begin n_fail++; $display("FAIL up_m10_tc[%0d] got %b exp %b", i, tc10, exp_q[i] == 9); end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; en = 1'b0; up = 1'b1; din = 4'd13;
    tick();
    n_checks++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL load_clamp_q got %0d exp 9", q10); end
    n_checks++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL load_clamp_wrap got %b exp 0", wrap10); end
    // q=9 counting up would wrap; load must win and suppress it.
    load = 1'b1; en = 1'b1; din = 4'd5;
    tick();
    n_checks++;
    if (q10 !== 4'd5) begin n_fail++; $display("FAIL load_over_en_q got %0d exp 5", q10); end
    n_checks++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL load_over_en_wrap got %b exp 0", wrap10); end
    load = 1'b0; en = 1'b0;
    tick();
    n_checks++;
    if (q10 !== 4'd5) begin n_fail++; $display("FAIL hold_q got %0d exp 5", q10); end
  endtask

  task automatic test_async_reset();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    n_checks++;
    if (q10 !== 4'd6) begin n_fail++; $display("FAIL pre_reset_q got %0d exp 6", q10); end
    en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL async_reset_q got %0d exp 0", q10); end
    n_checks++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL async_reset_wrap got %b exp 0", wrap10); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (q10 !== 4'd0) begin n_fail++; $display("FAIL post_reset_hold_q[%0d] got %0d exp 0", i, q10); end
    end
    en = 1'b1; up = 1'b0;
    tick();
`ifdef COUNTER_SATURATE_EN
    n_checks++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL first_down_q got %0d exp 0", q10); end
    n_checks++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL first_down_wrap got %b exp 0", wrap10); end
`else
    n_checks++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL first_down_q got %0d exp 9", q10); end
    n_checks++;
    if (wrap10 !== 1'b1) begin n_fail++; $display("FAIL first_down_wrap got %b exp 1", wrap10); end
    en = 1'b0;
    tick();
    n_checks++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle got %b exp 0", wrap10); end
`endif
    en = 1'b0;
  endtask

  task automatic test_direction();
    int exp_q [3];
    logic dir [3];
    exp_q = '{5, 4, 3};
    dir   = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; din = 4'd4; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up = dir[i];
      #1;
      n_checks++;
      if (tc10 !== 1'b0) begin n_fail++; $display("FAIL dir_tc_pre[%0d] got %b exp 0", i, tc10); end
      tick();
      n_checks++;
      if (q10 !== 4'(exp_q[i])) begin n_fail++; $display("FAIL dir_q[%0d] got %0d exp %0d", i, q10, exp_q[i]); end
      n_checks++;
      if (tc10 !== 1'b0) begin n_fail++; $display("FAIL dir_tc_post[%0d] got %b exp 0", i, tc10); end
    end
    en = 1'b0;
  endtask

  task automatic test_bound();
    int exp_q [4];
`ifdef COUNTER_SATURATE_EN
    exp_q = '{9, 9, 9, 9};
`else
    exp_q = '{9, 0, 1, 2};
`endif
    load = 1'b1; din = 4'd8; en = 1'b0; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (q10 !== 4'(exp_q[i])) begin n_fail++; $display("FAIL bound_q[%0d] got %0d exp %0d", i, q10, exp_q[i]); end
`ifdef COUNTER_SATURATE_EN
      n_checks++;
      if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL bound_wrap[%0d] got %b exp 0", i, wrap10); end
      n_checks++;
      if (tc10 !== 1'b1) begin n_fail++; $display("FAIL bound_tc[%0d] got %b exp 1", i, tc10); end
`else
      n_checks++;
      if (wrap10 !== (i == 1)) begin n_fail++; $display("FAIL bound_wrap[%0d] got %b exp %b", i, wrap10, i == 1); end
`endif
    end
    up = 1'b0;
    tick();
`ifdef COUNTER_SATURATE_EN
    n_checks++;
    if (q10 !== 4'd8) begin n_fail++; $display("FAIL bound_down_q got %0d exp 8", q10); end
`else
    n_checks++;
    if (q10 !== 4'd1) begin n_fail++; $display("FAIL bound_down_q got %0d exp 1", q10); end
`endif
    en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_down_w2();
    test_up_mod10();
    test_load_clamp();
    test_async_reset();
    test_direction();
    test_bound();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
